// File: rtl/sega_pad6.sv
// sega_pad6: behavioural six-button control pad on an SMS/Genesis port.
// Samples the TH select line, counts TH falling edges to step through the
// extended-button phases, and drives D0-D3/TL/TR back to the port (active-low).
// An idle timeout on TH returns the phase counter to 0.
// Optional build macro PAD6_MODE_LOCK_EN: holding Mode while reset is released
// locks the pad into three-button behaviour until the next reset.
module sega_pad6 #(
  parameter int TIMEOUT_CYCLES = 16384,
  parameter int TO_W           = 15
) (
  input  logic        MCLK,
  input  logic        rst,
  input  logic        TH_i,
  input  logic        TH_d,
  input  logic [11:0] BTN,
  output logic [5:0]  PAD_o
);

  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);
  localparam logic [2:0]      PH_XYZ  = 3'd3;
  localparam logic [2:0]      PH_ONES = 3'd4;

  // TH treated as high while the port leaves it as an input (pad pull-up).
  logic th_eff;
  assign th_eff = TH_d | TH_i;

  logic th_s1_q, th_s2_q, th_dly_q;
  logic th_fall, th_rise;

  logic [2:0]      cnt_q, cnt_d, cnt_max;
  logic [TO_W-1:0] to_q, to_d;
  logic [5:0]      pad_q, pad_d;
  logic [11:0]     btn_n;

  assign btn_n = ~BTN;

  // Two-flop synchronizer for TH plus a delayed copy for edge detection.
  always_ff @(posedge MCLK) begin
    if (!rst) begin
      th_s1_q  <= 1'b1;
      th_s2_q  <= 1'b1;
      th_dly_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of
      // its neighbour; blocking here would collapse the chain into a single flop.
      th_s1_q  <= th_eff;
      th_s2_q  <= th_s1_q;
      th_dly_q <= th_s2_q;
    end
  end

  assign th_fall = th_dly_q & ~th_s2_q;
  assign th_rise = ~th_dly_q & th_s2_q;

`ifdef PAD6_MODE_LOCK_EN
  logic lock_q, rel_q;

  // Sample Mode once, in the first cycle after reset release, to pick three-button mode.
  always_ff @(posedge MCLK) begin
    if (!rst) begin
      lock_q <= 1'b0;
      rel_q  <= 1'b0;
    end else if (!rel_q) begin
      lock_q <= BTN[11];
      rel_q  <= 1'b1;
    end
  end

  assign cnt_max = lock_q ? 3'd2 : PH_ONES;
`else
  assign cnt_max = PH_ONES;
`endif

  // Next phase and idle-timeout values; a falling edge beats a timeout expiring in the same cycle.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    cnt_d = cnt_q;
    to_d  = to_q;
    if (th_fall || th_rise) begin
      to_d = '0;
    end else if (to_q != TO_MAX) begin
      to_d = to_q + TO_W'(1);
    end
    if (th_fall) begin
      if (cnt_q < cnt_max) cnt_d = cnt_q + 3'd1;
    end else if (to_d == TO_MAX) begin
      cnt_d = 3'd0;
    end
  end

  // Phase counter and idle-timeout counter registers.
  always_ff @(posedge MCLK) begin
    if (!rst) begin
      cnt_q <= 3'd0;
      to_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  // Output mux. TH select uses the delayed copy so it changes in the same cycle as
  // the phase counter, and the pins never show a new TH level paired with a stale phase.
  always_comb begin
    pad_d = 6'h3F;
    if (th_dly_q) begin
      pad_d[5:4] = {btn_n[6], btn_n[5]};
      if (cnt_q == PH_XYZ) pad_d[3:0] = {btn_n[11], btn_n[8], btn_n[9], btn_n[10]};
      else                 pad_d[3:0] = {btn_n[3], btn_n[2], btn_n[1], btn_n[0]};
    end else begin
      pad_d[5:4] = {btn_n[7], btn_n[4]};
      case (cnt_q)
        PH_XYZ:  pad_d[3:0] = 4'h0;
        PH_ONES: pad_d[3:0] = 4'hF;
        default: pad_d[3:0] = {2'b00, btn_n[1], btn_n[0]};
      endcase
    end
  end

  // Registered pad pins.
  always_ff @(posedge MCLK) begin
    if (!rst) pad_q <= 6'h3F;
    else      pad_q <= pad_d;
  end

  assign PAD_o = pad_q;

endmodule

// File: tb/tb_sega_pad6.sv
// tb_sega_pad6: self-checking bench for sega_pad6. A directed vector table covers
// reset, TH latency, the six-button phase sequence, timeout and mid-sequence reset;
// a randomized run compares every cycle against a history-based reference model.
module tb_sega_pad6;

  localparam int TO = 16384;

  localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_A = 4, B_B = 5;
  localparam int B_C = 6, B_START = 7, B_X = 8, B_Y = 9, B_Z = 10, B_MODE = 11;

  logic        MCLK;
  logic        rst;
  logic        TH_i;
  logic        TH_d;
  logic [11:0] BTN;
  logic [5:0]  PAD_o;

  sega_pad6 #(.TIMEOUT_CYCLES(TO), .TO_W(15)) dut (
    .MCLK  (MCLK),
    .rst   (rst),
    .TH_i  (TH_i),
    .TH_d  (TH_d),
    .BTN   (BTN),
    .PAD_o (PAD_o)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: PAD_o=%h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The pad reacts to the TH level the host drove three clocks earlier; the model
  // keeps the last four host TH levels and derives phase/timeout from them.
  logic       th_hist[$];
  int         m_phase;
  int         m_idle;
  logic [5:0] m_pad;
  logic       m_lock;
  logic       m_rel;

  function automatic logic [5:0] pad_map(input logic th, input int phase, input logic [11:0] b);
    logic [3:0] d;
    logic       tl, tr;
    if (th) begin
      tl = !b[B_B];
      tr = !b[B_C];
      if (phase == 3) d = {!b[B_MODE], !b[B_X], !b[B_Y], !b[B_Z]};
      else            d = {!b[B_RIGHT], !b[B_LEFT], !b[B_DOWN], !b[B_UP]};
    end else begin
      tl = !b[B_A];
      tr = !b[B_START];
      if (phase == 3)      d = 4'h0;
      else if (phase == 4) d = 4'hF;
      else                 d = {2'b00, !b[B_DOWN], !b[B_UP]};
    end
    return {tr, tl, d};
  endfunction

  task automatic model_edge(input logic r, input logic th, input logic [11:0] b);
    logic seen_prev, seen_now;
    int   cap;
    if (!r) begin
      th_hist = {1'b1, 1'b1, 1'b1, 1'b1};
      m_phase = 0;
      m_idle  = 0;
      m_pad   = 6'h3F;
      m_lock  = 1'b0;
      m_rel   = 1'b0;
    end else begin
      th_hist.push_back(th);
      void'(th_hist.pop_front());
      seen_prev = th_hist[0];
      seen_now  = th_hist[1];
      m_pad = pad_map(seen_prev, m_phase, b);
      cap = m_lock ? 2 : 4;
      if (seen_prev != seen_now) begin
        m_idle = 0;
        if (seen_prev && !seen_now && m_phase < cap) m_phase++;
      end else begin
        if (m_idle < TO) m_idle++;
        if (m_idle == TO) m_phase = 0;
      end
`ifdef PAD6_MODE_LOCK_EN
      if (!m_rel) begin
        m_lock = b[B_MODE];
        m_rel  = 1'b1;
      end
`endif
    end
  endtask

  // Apply one cycle of inputs, advance one clock, update the model, sample after the edge.
  task automatic step(input logic r, input logic thd, input logic thi, input logic [11:0] b);
    rst  = r;
    TH_d = thd;
    TH_i = thi;
    BTN  = b;
    @(posedge MCLK);
    model_edge(r, thd | thi, b);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        r;
    logic        thd;
    logic        thi;
    logic [11:0] btn;
    int          n;
    logic [5:0]  exp;
    string       name;
  } vec_t;

  vec_t tv[$];

  function automatic void add(input logic r, input logic thd, input logic thi,
                              input logic [11:0] b, input int n, input logic [5:0] e,
                              input string name);
    vec_t v;
    v.r = r; v.thd = thd; v.thi = thi; v.btn = b; v.n = n; v.exp = e; v.name = name;
    tv.push_back(v);
  endfunction

  initial begin
    logic        rr, rthd, rthi;
    logic [11:0] rb;
    int          len;

    rst = 1'b0; TH_d = 1'b1; TH_i = 1'b0; BTN = '0;
    model_edge(1'b0, 1'b1, '0);

    add(0, 1, 0, 12'h000, 3, 6'h3F, "reset");
    add(1, 1, 0, 12'h000, 4, 6'h3F, "idle_th_input");
    add(1, 0, 1, 12'h091, 5, 6'h3E, "up_th_hi");
    add(1, 0, 0, 12'h091, 3, 6'h3E, "th_fall_lat3");
    add(1, 0, 0, 12'h091, 1, 6'h02, "th_fall_lat4_cnt1");
    add(1, 0, 1, 12'hC10, 4, 6'h3F, "hi_cnt1");
    add(1, 0, 0, 12'hC10, 4, 6'h23, "lo_cnt2");
    add(1, 0, 1, 12'hC10, 4, 6'h3F, "hi_cnt2");
    add(1, 0, 0, 12'hC10, 4, 6'h20, "lo_cnt3_zero");
    add(1, 0, 1, 12'hC10, 4, 6'h36, "hi_cnt3_xyz");
    add(1, 0, 0, 12'hC10, 4, 6'h2F, "lo_cnt4_ones");
    add(1, 0, 1, 12'hC10, 4, 6'h3F, "hi_cnt4_normal");
    add(1, 0, 0, 12'hC10, 4, 6'h2F, "lo_sat4");
    add(1, 0, 1, 12'hC10, TO - 10, 6'h3F, "hold_short");
    add(1, 0, 0, 12'hC10, 4, 6'h2F, "no_timeout_sat4");
    add(1, 0, 1, 12'hC10, TO + 5, 6'h3F, "hold_long");
    add(1, 0, 0, 12'hC10, 4, 6'h23, "timeout_cnt1");
    add(1, 0, 1, 12'hC10, 4, 6'h3F, "to_hi1");
    add(1, 0, 0, 12'hC10, 4, 6'h23, "to_lo_cnt2");
    add(1, 0, 1, 12'hC10, 4, 6'h3F, "to_hi2");
    add(1, 0, 0, 12'hC10, 4, 6'h20, "to_lo_cnt3");
    add(1, 0, 1, 12'hC10, 4, 6'h36, "pre_rst_xyz");
    add(0, 0, 1, 12'hC10, 1, 6'h3F, "rst_mid_seq");
    add(1, 0, 1, 12'hC10, 4, 6'h3F, "post_rst_hi");
    add(1, 0, 0, 12'hC10, 4, 6'h23, "post_rst_cnt1");
    add(1, 0, 1, 12'hC10, 4, 6'h3F, "post_rst_hi1");
    add(1, 0, 0, 12'hC10, 4, 6'h23, "post_rst_cnt2");
    add(1, 0, 1, 12'hC10, 4, 6'h3F, "post_rst_hi2");
    add(1, 0, 0, 12'hC10, 4, 6'h20, "post_rst_cnt3");
    add(1, 0, 1, 12'hC10, 4, 6'h36, "post_rst_xyz");

    foreach (tv[i]) begin
      for (int c = 0; c < tv[i].n; c++) step(tv[i].r, tv[i].thd, tv[i].thi, tv[i].btn);
      check(tv[i].name, PAD_o, tv[i].exp);
    end

`ifdef PAD6_MODE_LOCK_EN
    // Mode held through reset release: Z pulses must never reach D0, no all-zero phase.
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 1'b1, 12'h800);
    step(1'b1, 1'b0, 1'b1, 12'h800);
    for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 1'b1, 12'h400);
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 1'b0, 12'h400);
      check("lock_lo", PAD_o, 6'h33);
      for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 1'b1, 12'h400);
      check("lock_hi", PAD_o, 6'h3F);
    end
`endif

    // Randomized segments: hold lengths around the pipeline depth, occasional reset,
    // occasional TH-as-input, random buttons; every cycle checked against the model.
    for (int seg = 0; seg < 500; seg++) begin
      rr   = ($urandom_range(0, 39) != 0);
      rthd = ($urandom_range(0, 5) == 0);
      rthi = 1'($urandom_range(0, 1));
      rb   = 12'($urandom);
      len  = $urandom_range(1, 9);
      for (int c = 0; c < len; c++) begin
        step(rr, rthd, rthi, rb);
        check("random", PAD_o, m_pad);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
